led_pio_blink: RTL and testbench
================================

// Module: led_pio_blink
// PURPOSE
//  Avalon-MM slave output PIO driving board LEDs. Generalises the fixed 5-bit LED port
//  to WIDTH channels and adds atomic set/clear/toggle registers.
//  Adds per-channel hardware blinking from a shared programmable half-period counter.
//  Sits on the system interconnect as a memory-mapped slave; out_port goes to the pins.
// PARAMETERS
//  WIDTH       5   number of output channels, 1..32
//  CNT_W       24  width of PERIOD register and blink counter, 1..32
//  RESET_DATA  0   DATA register value after reset, WIDTH bits
//  RESET_PER   0   PERIOD register value after reset, CNT_W bits (0 = blink frozen)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset_n     in   1      asynchronous active-low reset
//  address     in   3      word address of register
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data
//  readdata    out  32     read data, zero-wait-state
//  out_port    out  WIDTH  LED drive
// BEHAVIOUR
//  Write = chipselect && !write_n; state is updated on the next clk edge; 1 write/cycle max.
//  Register map (read value / write effect):
//   0 DATA   r: data            w: data <= wd[WIDTH-1:0]
//   1 SET    r: data            w: data <= data | wd[WIDTH-1:0]
//   2 CLEAR  r: data            w: data <= data & ~wd[WIDTH-1:0]
//   3 TOGGLE r: data            w: data <= data ^ wd[WIDTH-1:0]
//   4 BLINK  r: blink_en        w: blink_en <= wd[WIDTH-1:0]
//   5 PERIOD r: period          w: period <= wd[CNT_W-1:0]; cnt <= 0; phase <= 1
//   6 STATUS r: {phase,cnt} as bit31=phase, [CNT_W-1:0]=cnt   w: ignored
//   7 --     r: 0               w: ignored
//  readdata: combinational from address and registers; no chipselect/read qualification;
//   unused upper bits are 0.
//  Blink counter:
//   - period == 0: cnt held at 0, phase held at its current value.
//   - otherwise: cnt increments each clk; when cnt == period-1, next cnt = 0 and phase toggles.
//   - Each phase level lasts exactly `period` cycles; full blink cycle = 2*period clocks.
//   - period == 1 toggles phase every clk.
//   - A PERIOD write in the same cycle as a wrap wins: cnt = 0, phase = 1, no toggle.
//   - Writing a period smaller than the current cnt is covered by the cnt reset above.
//  Output: out_port[i] = data[i] & (blink_en[i] ? phase : 1'b1).
//   - Combinational AND of flops only, so glitch-free at the pins.
//   - Reflects a write the cycle after the write edge.
//  Reset (async, any time including mid-blink):
//   - data = RESET_DATA, blink_en = 0, period = RESET_PER, cnt = 0, phase = 1.
//   - Therefore out_port = RESET_DATA.
//   - Reset release resumes counting on the first clk edge with reset_n high.
//  Writes with chipselect=0 or write_n=1 change nothing.
//  Writes to STATUS or to address 7 change nothing.
// TESTING
//  1 Reset, then write DATA=0x15, read addr0 -> readdata=0x15, out_port=5'h15;
//    write SET 0x0A -> 0x1F; write CLEAR 0x03 -> 0x1C; write TOGGLE 0x11 -> 0x0D.
//  2 Write data 0x1F with chipselect=0, then write addr7 = 0xFFFFFFFF
//    -> data and out_port unchanged, read addr7 = 0.
//  3 DATA=0x1F, BLINK=0x01, PERIOD=4 -> out_port[0] high 4 clk, low 4 clk, repeating;
//    bits 4:1 stay high; STATUS cnt sequence is 0,1,2,3,0.
//  4 With PERIOD=4 running, write PERIOD=0 at cnt=2 -> cnt=0 and phase=1, both frozen;
//    then write PERIOD=1 -> phase toggles every clk.
//  5 Issue a PERIOD=3 write on the cycle where cnt==period-1
//    -> next cnt=0, phase=1 (no toggle).
//  6 Assert reset_n low mid-blink between clk edges -> out_port=RESET_DATA immediately;
//    after release, first phase-high interval lasts exactly `period` clocks.

Source files
------------

// File: rtl/led_pio_blink_if.sv
// ============================================================================
// Module      : led_pio_blink_if
// Description : Avalon-MM slave bus bundle for the LED PIO register block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pio_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/led_pio_blink.sv
// ============================================================================
// Module      : led_pio_blink
// Description : Memory-mapped LED output PIO with set/clear/toggle access and
//               per-channel blinking from a shared half-period counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pio_blink #(
    parameter int                 WIDTH      = 5,
    parameter int                 CNT_W      = 24,
    parameter logic [WIDTH-1:0]   RESET_DATA = '0,
    parameter logic [CNT_W-1:0]   RESET_PER  = '0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    led_pio_blink_if.slave        bus,
    output logic [WIDTH-1:0]      out_port
);

    localparam logic [2:0] c_addr_data   = 3'd0;
    localparam logic [2:0] c_addr_set    = 3'd1;
    localparam logic [2:0] c_addr_clear  = 3'd2;
    localparam logic [2:0] c_addr_toggle = 3'd3;
    localparam logic [2:0] c_addr_blink  = 3'd4;
    localparam logic [2:0] c_addr_period = 3'd5;
    localparam logic [2:0] c_addr_status = 3'd6;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    logic             w_wr;
    logic             w_period_wr;
    logic [WIDTH-1:0] w_wd;
    logic [31:0]      w_status;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_period_wr = w_wr && (bus.address == c_addr_period);
    assign w_wd        = bus.writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RESET_DATA;
            r_blink_en <= '0;
            r_period   <= RESET_PER;
        end else if (w_wr) begin
            case (bus.address)
                c_addr_data:   r_data     <= w_wd;
                c_addr_set:    r_data     <= r_data | w_wd;
                c_addr_clear:  r_data     <= r_data & ~w_wd;
                c_addr_toggle: r_data     <= r_data ^ w_wd;
                c_addr_blink:  r_blink_en <= w_wd;
                c_addr_period: r_period   <= bus.writedata[CNT_W-1:0];
                default:       ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle and takes priority over a wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_period_wr) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_period == '0) begin
            r_cnt   <= '0;
        end else if (r_cnt == r_period - c_cnt_one) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_cnt_one;
        end
    end

    // Phase sits in bit 31 and overrides the counter MSB when CNT_W is 32.
    always_comb begin
        w_status     = 32'(r_cnt);
        w_status[31] = r_phase;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            c_addr_data,
            c_addr_set,
            c_addr_clear,
            c_addr_toggle: bus.readdata = 32'(r_data);
            c_addr_blink:  bus.readdata = 32'(r_blink_en);
            c_addr_period: bus.readdata = 32'(r_period);
            c_addr_status: bus.readdata = w_status;
            default:       bus.readdata = '0;
        endcase
    end

    assign out_port = r_data & (~r_blink_en | {WIDTH{r_phase}});

endmodule

`default_nettype wire

// File: tb/tb_led_pio_blink.sv
// ============================================================================
// Module      : tb_led_pio_blink
// Description : Scoreboard bench for the LED PIO: register access, blinking,
//               period-write priority and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pio_blink;

    localparam int               c_width   = 5;
    localparam int               c_cnt_w   = 24;
    localparam logic [4:0]       c_rst_dat = 5'h0A;
    localparam logic [23:0]      c_rst_per = 24'd3;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [c_width-1:0] out_port;

    led_pio_blink_if bus ();

    led_pio_blink #(
        .WIDTH      (c_width),
        .CNT_W      (c_cnt_w),
        .RESET_DATA (c_rst_dat),
        .RESET_PER  (c_rst_per)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
        observe(32'(out_port));
    endtask

    task automatic expect_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        sb.push_back('{tag, exp});
        bus.address = addr;
        #1;
        observe(bus.readdata);
    endtask

    // Called at a falling edge; the access is taken on the following rising edge.
    task automatic bus_drive(input logic cs, input logic wn, input logic [2:0] addr,
                             input logic [31:0] wd);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = addr;
        bus.writedata  = wd;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] wd);
        bus_drive(1'b1, 1'b0, addr, wd);
    endtask

    initial begin
        logic       ph;
        logic [4:0] ov;

        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;

        repeat (2) @(negedge clk);
        expect_out("rst_out", 32'h0A);
        expect_reg("rst_data", 3'd0, 32'h0A);
        expect_reg("rst_blink", 3'd4, 32'h0);
        expect_reg("rst_period", 3'd5, 32'd3);
        expect_reg("rst_status", 3'd6, 32'h8000_0000);
        expect_reg("rst_addr7", 3'd7, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Register access and atomic bit operations
        bus_write(3'd0, 32'h15);
        expect_reg("data_rd", 3'd0, 32'h15);
        expect_out("data_out", 32'h15);
        bus_write(3'd1, 32'h0A);
        expect_reg("set_rd", 3'd1, 32'h1F);
        expect_out("set_out", 32'h1F);
        bus_write(3'd2, 32'h03);
        expect_reg("clr_rd", 3'd2, 32'h1C);
        expect_out("clr_out", 32'h1C);
        bus_write(3'd3, 32'h11);
        expect_reg("tog_rd", 3'd3, 32'h0D);
        expect_out("tog_out", 32'h0D);

        // Unqualified writes and ignored addresses
        bus_drive(1'b0, 1'b0, 3'd0, 32'h1F);
        expect_reg("nocs_rd", 3'd0, 32'h0D);
        bus_drive(1'b1, 1'b1, 3'd0, 32'h1F);
        expect_reg("nowr_rd", 3'd0, 32'h0D);
        bus_write(3'd7, 32'hFFFF_FFFF);
        expect_reg("a7_data", 3'd0, 32'h0D);
        expect_out("a7_out", 32'h0D);
        expect_reg("a7_rd", 3'd7, 32'h0);
        expect_reg("a7_blink", 3'd4, 32'h0);

        // Blink on channel 0 with a 4-cycle half period
        bus_write(3'd0, 32'h1F);
        bus_write(3'd4, 32'h01);
        expect_reg("blink_rd", 3'd4, 32'h01);
        bus_write(3'd5, 32'd4);
        for (int i = 0; i < 16; i++) begin
            ph = ((i / 4) % 2) == 0;
            ov = ph ? 5'h1F : 5'h1E;
            expect_reg("blink_status", 3'd6, {ph, 7'd0, 24'(i % 4)});
            expect_out("blink_out", 32'(ov));
            @(negedge clk);
        end

        // Freeze at cnt==2, then run at the fastest rate
        @(negedge clk);
        @(negedge clk);
        expect_reg("pre_freeze", 3'd6, 32'h8000_0002);
        bus_write(3'd5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_reg("frozen_status", 3'd6, 32'h8000_0000);
            @(negedge clk);
        end
        bus_write(3'd6, 32'hFFFF_FFFF);
        expect_reg("status_wr_ign", 3'd6, 32'h8000_0000);
        expect_reg("period0_rd", 3'd5, 32'd0);
        bus_write(3'd5, 32'd1);
        for (int i = 0; i < 6; i++) begin
            ph = (i % 2) == 0;
            expect_reg("p1_status", 3'd6, {ph, 31'd0});
            expect_out("p1_out", ph ? 32'h1F : 32'h1E);
            @(negedge clk);
        end

        // PERIOD write landing on the wrap cycle
        bus_write(3'd5, 32'd4);
        repeat (3) @(negedge clk);
        expect_reg("pre_wrap", 3'd6, 32'h8000_0003);
        bus_write(3'd5, 32'd3);
        for (int i = 0; i < 4; i++) begin
            ph = i < 3;
            expect_reg("wrap_status", 3'd6, {ph, 7'd0, 24'(i % 3)});
            expect_out("wrap_out", ph ? 32'h1F : 32'h1E);
            @(negedge clk);
        end

        // Asynchronous reset while the LED is in its low phase
        expect_out("pre_rst_out", 32'h1E);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst_out", 32'h0A);
        expect_reg("async_rst_status", 3'd6, 32'h8000_0000);
        @(negedge clk);
        reset_n = 1'b1;
        expect_reg("rel_period", 3'd5, 32'd3);
        for (int i = 0; i < 7; i++) begin
            ph = ((i / 3) % 2) == 0;
            expect_reg("rel_status", 3'd6, {ph, 7'd0, 24'(i % 3)});
            @(negedge clk);
        end
        expect_out("rel_out", 32'h0A);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
